serial_divisibility_scheduler: RTL and testbench



---
 rtl/serial_divisibility_scheduler.sv | 74 +++++++
 tb/tb_serial_divisibility_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_divisibility_scheduler.sv
// serial_divisibility_scheduler: two requesters share one serial mod-MODULUS engine via round-robin; SERIAL_DIV_REMAINDER_OUT_EN adds out_rem
module serial_divisibility_scheduler #(
   parameter int WIDTH = 8,
   parameter int MODULUS = 5,
   localparam int RW = $clog2(MODULUS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       in_valid,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   output logic [1:0]       in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_div,
   output logic             out_id,
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
   output logic [RW-1:0]    out_rem,
`endif
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [RW:0] M = (RW+1)'(MODULUS);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, next;
   logic [WIDTH-1:0] shreg;
   logic [RW-1:0] rem, rem_next;
   logic [CW-1:0] cnt;
   logic id, last;
   logic [1:0] grant;
   logic [RW:0] dbl;
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= next;
   end
   // arbitration, remainder step (2r+bit < 2M so one conditional subtract), next state and outputs
   always_comb begin
      grant = (in_valid == 2'b11) ? (last ? 2'b01 : 2'b10) : in_valid;
      dbl = {rem, shreg[WIDTH-1]};
      rem_next = (dbl >= M) ? RW'(dbl - M) : RW'(dbl);
      next = (state == IDLE)  ? (|grant ? SHIFT : IDLE) :
             (state == SHIFT) ? ((cnt == CW'(WIDTH - 1)) ? DONE : SHIFT) :
             (state == DONE)  ? (out_ready ? IDLE : DONE) : IDLE;
      in_ready = (state == IDLE) ? grant : 2'b00;
      out_valid = (state == DONE);
      out_div = out_valid && (rem == '0);
      out_id = id;
      busy = (state != IDLE);
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
      out_rem = out_valid ? rem : '0;
`endif
   end
   // datapath: capture on grant, shift MSB-first while in SHIFT; last starts at 1 so requester 0 wins first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg <= '0;
         rem <= '0;
         cnt <= '0;
         id <= 1'b0;
         last <= 1'b1;
      end else if (state == IDLE && |grant) begin
         shreg <= grant[1] ? in_data1 : in_data0;
         rem <= '0;
         cnt <= '0;
         id <= grant[1];
         last <= grant[1];
      end else if (state == SHIFT) begin
         rem <= rem_next;
         shreg <= shreg << 1;
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// tb_serial_divisibility_scheduler: table, directed and randomized checks against an arithmetic model
module tb_serial_divisibility_scheduler;
   logic clk = 0, rst_n = 0;
   logic [1:0] in_valid = 0;
   logic [7:0] in_data0 = 0, in_data1 = 0;
   logic [1:0] in_ready;
   logic out_valid, out_ready = 0, out_div, out_id, busy;
   logic [1:0] v2 = 0;
   logic [3:0] d20 = 0, d21 = 0;
   logic [1:0] r2;
   logic ov2, od2, oi2, b2;
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
   logic [2:0] out_rem;
   logic [1:0] orem2;
`endif
   int n_cmp = 0, n_bad = 0, last_srv = 1, w;
   typedef struct {int r; logic [7:0] d; int hold; logic div; int rem;} vec_t;
   vec_t tab[5];

   always #5 clk = ~clk;

   serial_divisibility_scheduler #(.WIDTH(8), .MODULUS(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_div(out_div), .out_id(out_id),
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
      .out_rem(out_rem),
`endif
      .busy(busy));

   serial_divisibility_scheduler #(.WIDTH(4), .MODULUS(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data0(d20), .in_data1(d21),
      .in_ready(r2), .out_valid(ov2), .out_ready(1'b1), .out_div(od2), .out_id(oi2),
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
      .out_rem(orem2),
`endif
      .busy(b2));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // submit one word on requester r, wait for its result, hold out_ready low for hold cycles, then drain
   task automatic run(input int r, input logic [7:0] d, input int hold, input logic ediv, input int erem, output int wc);
      int lat;
      if (r == 1) in_data1 = d; else in_data0 = d;
      in_valid[r] = 1'b1;
      wc = 0;
      #1;
      while (!in_ready[r] && wc < 40) begin
         @(negedge clk);
         wc++;
         #1;
      end
      chk("grant", int'(in_ready[r]), 1);
      @(negedge clk);
      in_valid[r] = 1'b0;
      if (r == 1) in_data1 = ~d; else in_data0 = ~d;
      last_srv = r;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 9);
      for (int i = 0; i <= hold; i++) begin
         chk("out_valid", int'(out_valid), 1);
         chk("out_div", int'(out_div), int'(ediv));
         chk("out_id", int'(out_id), r);
         chk("in_ready_done", int'(in_ready), 0);
         chk("busy_done", int'(busy), 1);
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
         chk("out_rem", int'(out_rem), erem);
`endif
         if (i < hold) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_busy", int'(busy), 0);
   endtask

   task automatic run2(input int r, input logic [3:0] d);
      int k, lat;
      if (r == 1) d21 = d; else d20 = d;
      v2[r] = 1'b1;
      k = 0;
      #1;
      while (!r2[r] && k < 40) begin
         @(negedge clk);
         k++;
         #1;
      end
      chk("grant2", int'(r2[r]), 1);
      @(negedge clk);
      v2[r] = 1'b0;
      lat = 1;
      while (!ov2 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency2", lat, 5);
      chk("div2", int'(od2), int'((d % 3) == 0));
      chk("id2", int'(oi2), r);
`ifdef SERIAL_DIV_REMAINDER_OUT_EN
      chk("rem2", int'(orem2), int'(d % 3));
`endif
      @(negedge clk);
      chk("busy2_idle", int'(b2), 0);
   endtask

   initial begin
      tab[0] = '{0, 8'h0A, 0, 1'b1, 0};
      tab[1] = '{1, 8'h07, 0, 1'b0, 2};
      tab[2] = '{0, 8'hFF, 0, 1'b1, 0};
      tab[3] = '{0, 8'h00, 0, 1'b1, 0};
      tab[4] = '{1, 8'h0A, 5, 1'b1, 0};
      repeat (2) @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_div", int'(out_div), 0);
      chk("rst_id", int'(out_id), 0);
      chk("rst_ready", int'(in_ready), 0);
      in_valid = 2'b11;
      #1;
      chk("rst_prio0", int'(in_ready), 1);
      in_valid = 2'b00;
      @(negedge clk);
      rst_n = 1;
      in_data1 = 8'h0F;
      in_valid[1] = 1'b1;
      run(0, 8'h03, 0, 1'b0, 3, w);
      chk("rr_first_wait", w, 0);
      run(1, 8'h0F, 0, 1'b1, 0, w);
      chk("rr_second_wait", w, 0);
      in_data1 = 8'h14;
      in_valid[1] = 1'b1;
      run(0, 8'h06, 0, 1'b0, 1, w);
      chk("rr_again_wait", w, 0);
      run(1, 8'h14, 0, 1'b1, 0, w);
      for (int i = 0; i < 5; i++) begin
         run(tab[i].r, tab[i].d, tab[i].hold, tab[i].div, tab[i].rem, w);
         chk("tab_wait", w, 0);
      end
      in_data1 = 8'h0A;
      in_valid[1] = 1'b1;
      #1;
      chk("abort_grant", int'(in_ready), 2);
      @(negedge clk);
      in_valid = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      chk("abort_valid", int'(out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_id", int'(out_id), 0);
      rst_n = 1;
      last_srv = 1;
      run(0, 8'h19, 0, 1'b1, 0, w);
      repeat (40) begin
         int r, first;
         logic [7:0] d, d2;
         r = $urandom_range(0, 1);
         d = 8'($urandom);
         d2 = 8'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            first = 1 - last_srv;
            if (first == 1) begin in_data0 = d2; in_valid[0] = 1'b1; end
            else begin in_data1 = d2; in_valid[1] = 1'b1; end
            run(first, d, $urandom_range(0, 3), (d % 5) == 0, int'(d % 5), w);
            chk("rand_rr_wait", w, 0);
            run(1 - first, d2, 0, (d2 % 5) == 0, int'(d2 % 5), w);
            chk("rand_rr_second", w, 0);
         end else begin
            run(r, d, $urandom_range(0, 3), (d % 5) == 0, int'(d % 5), w);
            chk("rand_wait", w, 0);
         end
      end
      for (int i = 0; i < 16; i++) run2(i % 2, 4'(i));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
